// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: main control FSM of the multi-cycle RV32I core.
// Ports:
//   i_clk, i_srst_n            clock, synchronous active-low reset
//   i_operand, i_funct3,       latched instruction fields (opcode, funct3, bit 30)
//   i_funct7bit5
//   i_zeroFlag                 shared ALU zero flag
//   i_memReady                 unified memory finished the current access
//   o_memReq, o_adrSrc         memory request and address select (PC / ALU-out)
//   o_irWrite, o_pcWrite       instruction/oldPC load, PC load
//   o_memWriteEn, o_regWriteEn memory and register file write strobes
//   o_aluSrcA, o_aluSrcB       ALU operand selects
//   o_resultSrc                result bus select
//   o_aluLogicOperation        ALU operation (pa_riscv encoding)
//   o_instrRetired, o_trap     retire pulse, sticky illegal-instruction flag
//   o_state                    current state for debug
package pa_riscv;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
endpackage

module multi_cycle_controller
    import pa_riscv::*;
(
    input  logic       i_clk,
    input  logic       i_srst_n,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
    input  logic       i_memReady,
    output logic       o_memReq,
    output logic       o_adrSrc,
    output logic       o_irWrite,
    output logic       o_pcWrite,
    output logic       o_memWriteEn,
    output logic       o_regWriteEn,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_resultSrc,
    output logic [3:0] o_aluLogicOperation,
    output logic       o_instrRetired,
    output logic       o_trap,
    output logic [3:0] o_state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    state_t     state, next_state;
    logic       f3_ok;
    logic [3:0] alu_dec;
    logic       mem_req_q;
    // {trap, mem_req, adr_src, alu_src_a, alu_src_b, result_src}
    logic [8:0] moore_q;

    // Moore outputs are registered alongside the state, so they are derived
    // from the state being entered.
    function automatic logic [8:0] moore(input state_t s);
        case (s)
            FETCH:    moore = 9'b0_1_0_00_10_10;
            DECODE:   moore = 9'b0_0_0_01_01_00;
            MEMADR:   moore = 9'b0_0_0_10_01_00;
            MEMREAD:  moore = 9'b0_1_1_00_00_00;
            MEMWB:    moore = 9'b0_0_0_00_00_01;
            MEMWRITE: moore = 9'b0_1_1_00_00_00;
            EXECUTER: moore = 9'b0_0_0_10_00_00;
            EXECUTEI: moore = 9'b0_0_0_10_01_00;
            BEQ:      moore = 9'b0_0_0_10_00_00;
            JAL:      moore = 9'b0_0_0_01_10_00;
            TRAP:     moore = 9'b1_0_0_00_00_00;
            default:  moore = 9'b0_0_0_00_00_00;
        endcase
    endfunction

    always_comb begin
        f3_ok   = i_funct3 == 3'b000 || i_funct3 == 3'b111 || i_funct3 == 3'b110 || i_funct3 == 3'b010;
        // funct7 bit 5 only selects SUB for register-register ops; addi is never SUB
        alu_dec = i_funct3 == 3'b111 ? ALU_AND :
                  i_funct3 == 3'b110 ? ALU_OR  :
                  i_funct3 == 3'b010 ? ALU_SLT :
                  (i_funct3 == 3'b000 && i_funct7bit5 && state == EXECUTER) ? ALU_SUB : ALU_ADD;
        next_state = state;
        case (state)
            FETCH:    next_state = i_memReady ? DECODE : FETCH;
            DECODE:   next_state = (i_operand == OP_LOAD || i_operand == OP_STORE) ? MEMADR :
                                   i_operand == OP_RTYPE  ? EXECUTER :
                                   i_operand == OP_ITYPE  ? EXECUTEI :
                                   i_operand == OP_BRANCH ? BEQ :
                                   i_operand == OP_JAL    ? JAL : TRAP;
            MEMADR:   next_state = i_operand == OP_STORE ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = i_memReady ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = i_memReady ? FETCH : MEMWRITE;
            EXECUTER: next_state = f3_ok ? ALUWB : TRAP;
            EXECUTEI: next_state = f3_ok ? ALUWB : TRAP;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = i_funct3 == 3'b000 ? FETCH : TRAP;
            JAL:      next_state = ALUWB;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state   <= FETCH;
            moore_q <= moore(FETCH);
        end else begin
            state   <= next_state;
            moore_q <= moore(next_state);
        end
    end

    assign {o_trap, mem_req_q, o_adrSrc, o_aluSrcA, o_aluSrcB, o_resultSrc} = moore_q;

    // Every strobe is masked by reset so an abandoned instruction writes nothing.
    assign o_memReq       = i_srst_n && mem_req_q;
    assign o_irWrite      = i_srst_n && state == FETCH && i_memReady;
    assign o_pcWrite      = i_srst_n && ((state == FETCH && i_memReady) || state == JAL ||
                                         (state == BEQ && i_zeroFlag));
    assign o_memWriteEn   = i_srst_n && state == MEMWRITE;
    assign o_regWriteEn   = i_srst_n && (state == MEMWB || state == ALUWB);
    assign o_instrRetired = i_srst_n && (state == MEMWB || state == ALUWB ||
                                         (state == MEMWRITE && i_memReady) ||
                                         (state == BEQ && i_funct3 == 3'b000));
    assign o_aluLogicOperation = state == BEQ ? ALU_SUB :
                                 (state == EXECUTER || state == EXECUTEI) ? alu_dec : ALU_ADD;
    assign o_state = state;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: scoreboard bench for multi_cycle_controller.
// Stimulus drives one cycle at a time and queues the hand-computed outputs for
// that cycle; the monitor pops and compares on the falling edge.
module tb_multi_cycle_controller;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           LUI = 7'b0110111;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, SLT = 4'd4;
    // {memReq, adrSrc, irWrite, pcWrite, memWriteEn, regWriteEn, retired, trap,
    //  aluSrcA, aluSrcB, resultSrc, aluOp, state}
    localparam logic [21:0] RST_F  = {8'b0000_0000, 2'b00, 2'b10, 2'b10, 4'd0, 4'd0};
    localparam logic [21:0] FET_GO = {8'b1011_0000, 2'b00, 2'b10, 2'b10, 4'd0, 4'd0};
    localparam logic [21:0] FET_ST = {8'b1000_0000, 2'b00, 2'b10, 2'b10, 4'd0, 4'd0};
    localparam logic [21:0] DEC    = {8'b0000_0000, 2'b01, 2'b01, 2'b00, 4'd0, 4'd1};
    localparam logic [21:0] MADR   = {8'b0000_0000, 2'b10, 2'b01, 2'b00, 4'd0, 4'd2};
    localparam logic [21:0] MRD    = {8'b1100_0000, 2'b00, 2'b00, 2'b00, 4'd0, 4'd3};
    localparam logic [21:0] MWB    = {8'b0000_0110, 2'b00, 2'b00, 2'b01, 4'd0, 4'd4};
    localparam logic [21:0] MWB_R  = {8'b0000_0000, 2'b00, 2'b00, 2'b01, 4'd0, 4'd4};
    localparam logic [21:0] MWR_ST = {8'b1100_1000, 2'b00, 2'b00, 2'b00, 4'd0, 4'd5};
    localparam logic [21:0] MWR_GO = {8'b1100_1010, 2'b00, 2'b00, 2'b00, 4'd0, 4'd5};
    localparam logic [21:0] AWB    = {8'b0000_0110, 2'b00, 2'b00, 2'b00, 4'd0, 4'd8};
    localparam logic [21:0] BEQ_T  = {8'b0001_0010, 2'b10, 2'b00, 2'b00, 4'd1, 4'd9};
    localparam logic [21:0] BEQ_N  = {8'b0000_0010, 2'b10, 2'b00, 2'b00, 4'd1, 4'd9};
    localparam logic [21:0] JALV   = {8'b0001_0000, 2'b01, 2'b10, 2'b00, 4'd0, 4'd10};
    localparam logic [21:0] TRP    = {8'b0000_0001, 2'b00, 2'b00, 2'b00, 4'd0, 4'd11};

    logic       clk = 1'b0, srst_n = 1'b0, funct7bit5 = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;
    logic [6:0] operand = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       mem_req, adr_src, ir_write, pc_write, mem_write_en, reg_write_en, retired, trap;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op, state;
    logic [6:0] cur_op = 7'd0;
    logic [2:0] cur_f3 = 3'd0;
    logic       cur_b5 = 1'b0;
    int         vectors = 0, miscompares = 0;

    typedef struct {
        string       nm;
        logic [21:0] v;
    } exp_t;
    exp_t sb[$];

    multi_cycle_controller dut (
        .i_clk(clk), .i_srst_n(srst_n), .i_operand(operand), .i_funct3(funct3),
        .i_funct7bit5(funct7bit5), .i_zeroFlag(zero_flag), .i_memReady(mem_ready),
        .o_memReq(mem_req), .o_adrSrc(adr_src), .o_irWrite(ir_write), .o_pcWrite(pc_write),
        .o_memWriteEn(mem_write_en), .o_regWriteEn(reg_write_en), .o_aluSrcA(alu_src_a),
        .o_aluSrcB(alu_src_b), .o_resultSrc(result_src), .o_aluLogicOperation(alu_op),
        .o_instrRetired(retired), .o_trap(trap), .o_state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] exr(input logic [3:0] op);
        return {8'b0000_0000, 2'b10, 2'b00, 2'b00, op, 4'd6};
    endfunction

    function automatic logic [21:0] exi(input logic [3:0] op);
        return {8'b0000_0000, 2'b10, 2'b01, 2'b00, op, 4'd7};
    endfunction

    task automatic ld(input logic [6:0] op, input logic [2:0] f3, input logic b5);
        cur_op = op;
        cur_f3 = f3;
        cur_b5 = b5;
    endtask

    task automatic step(input string nm, input logic rn, input logic rdy, input logic z,
                        input logic [21:0] ex);
        exp_t e;
        @(posedge clk);
        #1;
        srst_n     = rn;
        mem_ready  = rdy;
        zero_flag  = z;
        operand    = cur_op;
        funct3     = cur_f3;
        funct7bit5 = cur_b5;
        e.nm = nm;
        e.v  = ex;
        sb.push_back(e);
    endtask

    initial begin
        exp_t        e;
        logic [21:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = {mem_req, adr_src, ir_write, pc_write, mem_write_en, reg_write_en, retired,
                       trap, alu_src_a, alu_src_b, result_src, alu_op, state};
                vectors++;
                if (got !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %b expected %b", e.nm, got, e.v);
                end
            end
        end
    end

    initial begin
        ld(LW, 3'b010, 1'b0);
        repeat (3) step("reset", 0, 1, 0, RST_F);
        step("lw.fetch", 1, 1, 0, FET_GO);
        step("lw.decode", 1, 1, 0, DEC);
        step("lw.memadr", 1, 1, 0, MADR);
        step("lw.memread", 1, 1, 0, MRD);
        step("lw.memwb", 1, 1, 0, MWB);
        ld(SW, 3'b010, 1'b0);
        step("sw.fetch", 1, 1, 0, FET_GO);
        step("sw.decode", 1, 0, 0, DEC);
        step("sw.memadr", 1, 0, 0, MADR);
        repeat (3) step("sw.memwrite_stall", 1, 0, 0, MWR_ST);
        step("sw.memwrite_go", 1, 1, 0, MWR_GO);
        ld(RT, 3'b000, 1'b1);
        step("sub.fetch", 1, 1, 0, FET_GO);
        step("sub.decode", 1, 1, 0, DEC);
        step("sub.exec", 1, 1, 0, exr(SUB));
        step("sub.aluwb", 1, 1, 0, AWB);
        ld(IT, 3'b000, 1'b1);
        step("addi.fetch", 1, 1, 0, FET_GO);
        step("addi.decode", 1, 1, 0, DEC);
        step("addi.exec", 1, 1, 0, exi(ADD));
        step("addi.aluwb", 1, 1, 0, AWB);
        ld(RT, 3'b010, 1'b0);
        step("slt.fetch", 1, 1, 0, FET_GO);
        step("slt.decode", 1, 1, 0, DEC);
        step("slt.exec", 1, 1, 0, exr(SLT));
        step("slt.aluwb", 1, 1, 0, AWB);
        ld(IT, 3'b010, 1'b0);
        step("slti.fetch", 1, 1, 0, FET_GO);
        step("slti.decode", 1, 1, 0, DEC);
        step("slti.exec", 1, 1, 0, exi(SLT));
        step("slti.aluwb", 1, 1, 0, AWB);
        ld(RT, 3'b111, 1'b0);
        step("and.fetch", 1, 1, 0, FET_GO);
        step("and.decode", 1, 1, 0, DEC);
        step("and.exec", 1, 1, 0, exr(AND_));
        step("and.aluwb", 1, 1, 0, AWB);
        ld(IT, 3'b110, 1'b0);
        step("ori.fetch", 1, 1, 0, FET_GO);
        step("ori.decode", 1, 1, 0, DEC);
        step("ori.exec", 1, 1, 0, exi(OR_));
        step("ori.aluwb", 1, 1, 0, AWB);
        ld(BR, 3'b000, 1'b0);
        step("beq_t.fetch", 1, 1, 0, FET_GO);
        step("beq_t.decode", 1, 1, 1, DEC);
        step("beq_t.beq", 1, 1, 1, BEQ_T);
        step("beq_n.fetch", 1, 1, 0, FET_GO);
        step("beq_n.decode", 1, 1, 0, DEC);
        step("beq_n.beq", 1, 1, 0, BEQ_N);
        ld(JL, 3'b000, 1'b0);
        step("jal.fetch", 1, 1, 0, FET_GO);
        step("jal.decode", 1, 1, 0, DEC);
        step("jal.jal", 1, 1, 0, JALV);
        step("jal.aluwb", 1, 1, 0, AWB);
        ld(LW, 3'b010, 1'b0);
        step("lws.fetch_stall", 1, 0, 0, FET_ST);
        step("lws.fetch", 1, 1, 0, FET_GO);
        step("lws.decode", 1, 0, 0, DEC);
        step("lws.memadr", 1, 0, 0, MADR);
        step("lws.memread_stall", 1, 0, 0, MRD);
        step("lws.memread", 1, 1, 0, MRD);
        step("lws.memwb", 1, 1, 0, MWB);
        step("lwr.fetch", 1, 1, 0, FET_GO);
        step("lwr.decode", 1, 1, 0, DEC);
        step("lwr.memadr", 1, 1, 0, MADR);
        step("lwr.memread", 1, 1, 0, MRD);
        step("lwr.memwb_reset", 0, 1, 0, MWB_R);
        step("lwr.after_reset", 1, 0, 0, FET_ST);
        ld(LUI, 3'b000, 1'b0);
        step("lui.fetch", 1, 1, 0, FET_GO);
        step("lui.decode", 1, 1, 1, DEC);
        for (int i = 0; i < 20; i++) step("lui.trap", 1, 1'(i), 1'(i >> 1), TRP);
        step("lui.trap_reset", 0, 1, 0, TRP);
        step("lui.cleared", 1, 1, 0, FET_GO);
        ld(RT, 3'b001, 1'b0);
        step("rbad.decode", 1, 1, 0, DEC);
        step("rbad.exec", 1, 1, 0, exr(ADD));
        step("rbad.trap", 1, 1, 0, TRP);
        ld(BR, 3'b001, 1'b0);
        step("bne.reset", 0, 1, 0, TRP);
        step("bne.fetch", 1, 1, 0, FET_GO);
        step("bne.decode", 1, 1, 0, DEC);
        step("bne.beq", 1, 1, 0, {8'b0000_0000, 2'b10, 2'b00, 2'b00, 4'd1, 4'd9});
        step("bne.trap", 1, 1, 0, TRP);
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core. One shared ALU and one unified instruction/data memory are used across several cycles per instruction.
- Decodes the latched instruction fields and steers the shared datapath muxes, register/memory write strobes and the ALU operation on every cycle.
- Supports the same subset as the single-cycle core: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal.
- Adds a memory-ready handshake and a sticky illegal-instruction trap.

Parameters:
- None. Opcode constants and ALU operation encodings (ADD, SUB, AND, OR, SLT) come from pa_riscv.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_srst_n  input  1  reset; synchronous, active-low.
- i_operand  input  7  opcode field from the instruction register.
- i_funct3  input  3  funct3 field.
- i_funct7bit5  input  1  bit 30 of the instruction.
- i_zeroFlag  input  1  ALU zero flag, combinational from the shared ALU.
- i_memReady  input  1  unified memory has completed the current access this cycle.
- o_memReq  output  1  memory access requested this cycle.
- o_adrSrc  output  1  memory address select: 0 = PC, 1 = ALU-out register.
- o_irWrite  output  1  load the instruction and oldPC registers.
- o_pcWrite  output  1  load PC from the result bus.
- o_memWriteEn  output  1  memory write.
- o_regWriteEn  output  1  register file write.
- o_aluSrcA  output  2  00 = PC, 01 = oldPC, 10 = rs1 register.
- o_aluSrcB  output  2  00 = rs2 register, 01 = immediateExtended, 10 = constant 4.
- o_resultSrc  output  2  00 = ALU-out register, 01 = memory data register, 10 = ALU result.
- o_aluLogicOperation  output  4  ALU operation (pa_riscv encoding).
- o_instrRetired  output  1  one-cycle pulse when an instruction completes.
- o_trap  output  1  sticky illegal-instruction flag.
- o_state  output  4  current state, for debug.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
- Reset:
  - While i_srst_n == 0 at a clock edge, the next state is FETCH and o_trap clears.
  - Reset mid-instruction abandons the instruction with no write strobes in the reset cycle.
- All outputs are Moore except:
  - the i_memReady gating of strobes;
  - o_pcWrite in BEQ;
  - the R/I-type ALU operation decode.
- Default per state: every strobe 0, mux selects 00, ALU op ADD.
- FETCH:
  - o_memReq=1, adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10.
  - irWrite and pcWrite equal i_memReady.
  - Stay while i_memReady=0; go to DECODE when it is 1.
- DECODE: aluSrcA=01, aluSrcB=01, ADD (precomputes the branch target). Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXECUTER
  - I-type ALU → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - any other opcode → TRAP
- MEMADR: aluSrcA=10, aluSrcB=01, ADD. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: memReq=1, adrSrc=1. Hold until i_memReady, then go to MEMWB.
- MEMWB: resultSrc=01, regWriteEn=1, retire. Next FETCH.
- MEMWRITE:
  - memReq=1, adrSrc=1, memWriteEn=1 held level until i_memReady.
  - Retire on the ready cycle, then FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00. ALU op decoded from funct3 / funct7bit5:
  - 000 with bit5=1 → SUB; 000 with bit5=0 → ADD
  - 111 → AND; 110 → OR; 010 → SLT
  - any other funct3 → TRAP instead of ALUWB
  - Otherwise next ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01. Same decode, but funct7bit5 is ignored (addi is never SUB). Unsupported funct3 → TRAP. Otherwise next ALUWB.
- ALUWB: resultSrc=00, regWriteEn=1, retire. Next FETCH.
- BEQ:
  - aluSrcA=10, aluSrcB=00, SUB, resultSrc=00.
  - pcWrite = i_zeroFlag.
  - funct3 ≠ 000 → TRAP. Otherwise retire and go to FETCH.
- JAL: aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, pcWrite=1. Next ALUWB, which writes rd = oldPC+4.
- TRAP: o_trap=1, all strobes 0, memReq=0. Remains until reset.
- o_instrRetired pulses exactly once per completed instruction. It is never asserted in a stalled cycle.
- i_memReady is ignored in states without memReq.

Test Plan:
- Reset: hold i_srst_n=0 for 3 cycles in any state, then release → o_state=FETCH, o_trap=0, all strobes 0 in reset cycles; first FETCH with i_memReady=1 gives irWrite=pcWrite=1.
- lw with ready always 1 → 5 cycles FETCH, DECODE, MEMADR, MEMREAD, MEMWB; single regWriteEn in MEMWB with resultSrc=01; one retire pulse.
- sw with i_memReady low for 3 cycles in MEMWRITE → memWriteEn held 4 cycles, regWriteEn never set, retire only on the ready cycle; total 7 cycles.
- R-type sub (funct3=000, bit5=1) → EXECUTER shows SUB; addi with bit5=1 → ADD; slt/slti → SLT; 4-cycle instructions.
- beq: zeroFlag=1 → pcWrite=1 in BEQ; zeroFlag=0 → pcWrite=0; both take 3 cycles. jal → pcWrite in JAL, then regWriteEn in ALUWB with resultSrc=00.
- Opcode 0110111 (lui, unsupported) → TRAP after DECODE, o_trap sticky for 20 cycles, no strobes; i_srst_n low clears it back to FETCH.
